// File: rtl/pipe_pkg.sv
// Shared types and constants for the EX/MEM and MEM/WB pipeline registers.
// Used by ex_mem_wb_pipe and, under PIPE_PERF_CNT_EN, pipe_perf_cnt.
package pipe_pkg;

    localparam int PIPE_DW = 32;
    localparam int PIPE_RW = 5;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic               valid;
        logic [PIPE_RW-1:0] rw;
        logic               regwr;
        logic               memtoreg;
        logic               memwr;
        logic [PIPE_DW-1:0] alu;
        logic [PIPE_DW-1:0] sdata;
    } exmem_t;

    typedef struct packed {
        logic               valid;
        logic [PIPE_RW-1:0] rw;
        logic               regwr;
        logic [PIPE_DW-1:0] data;
    } memwb_t;

    localparam exmem_t BUBBLE_EXMEM = '0;
    localparam memwb_t BUBBLE_MEMWB = '0;

endpackage

// File: rtl/ex_mem_wb_pipe_perf_cnt.sv
// Retired/bubble counters for the WB stage; instantiated only when
// PIPE_PERF_CNT_EN is defined.
module pipe_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        cap_valid,
    output logic [31:0] retired_cnt,
    output logic [31:0] bubble_cnt
);

    // Every non-reset edge MEM/WB captures either a real instruction or a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retired_cnt <= 32'd0;
            bubble_cnt  <= 32'd0;
        end else if (cap_valid) begin
            retired_cnt <= retired_cnt + 32'd1;
        end else begin
            bubble_cnt  <= bubble_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/ex_mem_wb_pipe.sv
// EX/MEM and MEM/WB pipeline registers of the five-stage MIPS core.
// Optional feature macro: PIPE_PERF_CNT_EN (adds retired_cnt/bubble_cnt ports).
module ex_mem_wb_pipe
    import pipe_pkg::*;
#(
    parameter int DW = PIPE_DW,
    parameter int RW = PIPE_RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    input  logic [RW-1:0] ex_rw,
    input  logic          ex_regwr,
    input  logic          ex_memtoreg,
    input  logic          ex_memwr,
    input  logic [DW-1:0] ex_alu,
    input  logic [DW-1:0] ex_sdata,
    input  logic          stall,
    input  logic          flush,
    input  logic [DW-1:0] dm_rdata,
    output logic [RW-1:0] mem_rw,
    output logic          mem_regwr,
    output logic          mem_memtoreg,
    output logic [DW-1:0] mem_alu,
    output logic          dm_we,
    output logic [DW-1:0] dm_addr,
    output logic [DW-1:0] dm_wdata,
    output logic [RW-1:0] wr_rw,
    output logic          wr_regwr,
    output logic [DW-1:0] wr_data
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]   retired_cnt,
    output logic [31:0]   bubble_cnt
`endif
);

    exmem_t exmem;
    memwb_t memwb;
    exmem_t ex_next;

    // Write-enable is qualified on entry so a write to $0 never leaves EX/MEM.
    always_comb begin
        ex_next          = BUBBLE_EXMEM;
        ex_next.valid    = ex_valid;
        ex_next.rw       = ex_rw;
        ex_next.regwr    = ex_regwr & ex_valid & (ex_rw != REG_ZERO);
        ex_next.memtoreg = ex_memtoreg;
        ex_next.memwr    = ex_memwr;
        ex_next.alu      = ex_alu;
        ex_next.sdata    = ex_sdata;
    end

    // Stall outranks flush: the EX instruction is not consumed, so it must not be killed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exmem <= BUBBLE_EXMEM;
            memwb <= BUBBLE_MEMWB;
        end else if (stall) begin
            memwb.valid <= 1'b0;
            memwb.regwr <= 1'b0;
            memwb.rw    <= REG_ZERO;
        end else begin
            memwb.valid <= exmem.valid;
            memwb.rw    <= exmem.rw;
            memwb.regwr <= exmem.regwr;
            memwb.data  <= exmem.memtoreg ? dm_rdata : exmem.alu;
            exmem       <= flush ? BUBBLE_EXMEM : ex_next;
        end
    end

    assign mem_rw       = exmem.rw;
    assign mem_regwr    = exmem.regwr;
    assign mem_memtoreg = exmem.memtoreg;
    assign mem_alu      = exmem.alu;
    assign dm_addr      = exmem.alu;
    assign dm_wdata     = exmem.sdata;
    assign dm_we        = exmem.memwr & exmem.valid & ~stall;

    assign wr_rw    = memwb.rw;
    assign wr_regwr = memwb.regwr;
    assign wr_data  = memwb.data;

`ifdef PIPE_PERF_CNT_EN
    pipe_perf_cnt u_perf_cnt (
        .clk         (clk),
        .rst         (rst),
        .cap_valid   (exmem.valid & ~stall),
        .retired_cnt (retired_cnt),
        .bubble_cnt  (bubble_cnt)
    );
`else
    logic unused_wb_valid;
    assign unused_wb_valid = memwb.valid;
`endif

endmodule

// File: tb/tb_ex_mem_wb_pipe.sv
// Self-checking bench for ex_mem_wb_pipe: a stage-level reference model compared
// every cycle, plus hand-computed expectations for the directed scenarios.
module tb_ex_mem_wb_pipe;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [4:0]  ex_rw;
    logic        ex_regwr;
    logic        ex_memtoreg;
    logic        ex_memwr;
    logic [31:0] ex_alu;
    logic [31:0] ex_sdata;
    logic        stall;
    logic        flush;
    logic [31:0] dm_rdata;
    logic [4:0]  mem_rw;
    logic        mem_regwr;
    logic        mem_memtoreg;
    logic [31:0] mem_alu;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [4:0]  wr_rw;
    logic        wr_regwr;
    logic [31:0] wr_data;
`ifdef PIPE_PERF_CNT_EN
    logic [31:0] retired_cnt;
    logic [31:0] bubble_cnt;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    ex_mem_wb_pipe dut (
        .clk          (clk),
        .rst          (rst),
        .ex_valid     (ex_valid),
        .ex_rw        (ex_rw),
        .ex_regwr     (ex_regwr),
        .ex_memtoreg  (ex_memtoreg),
        .ex_memwr     (ex_memwr),
        .ex_alu       (ex_alu),
        .ex_sdata     (ex_sdata),
        .stall        (stall),
        .flush        (flush),
        .dm_rdata     (dm_rdata),
        .mem_rw       (mem_rw),
        .mem_regwr    (mem_regwr),
        .mem_memtoreg (mem_memtoreg),
        .mem_alu      (mem_alu),
        .dm_we        (dm_we),
        .dm_addr      (dm_addr),
        .dm_wdata     (dm_wdata),
        .wr_rw        (wr_rw),
        .wr_regwr     (wr_regwr),
        .wr_data      (wr_data)
`ifdef PIPE_PERF_CNT_EN
        ,
        .retired_cnt  (retired_cnt),
        .bubble_cnt   (bubble_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: one record per stage, advanced by the stall/flush rules.
    logic        m_mem_valid, m_mem_regwr, m_mem_mtr, m_mem_mw;
    logic [4:0]  m_mem_rw;
    logic [31:0] m_mem_alu, m_mem_sdata;
    logic        m_wb_regwr;
    logic [4:0]  m_wb_rw;
    logic [31:0] m_wb_data;
    logic [31:0] m_retired, m_bubble;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            {m_mem_valid, m_mem_regwr, m_mem_mtr, m_mem_mw} = 4'b0;
            m_mem_rw = 5'd0; m_mem_alu = 32'd0; m_mem_sdata = 32'd0;
            m_wb_regwr = 1'b0; m_wb_rw = 5'd0; m_wb_data = 32'd0;
            m_retired = 32'd0; m_bubble = 32'd0;
        end else begin
            if (!stall && m_mem_valid) m_retired = m_retired + 32'd1;
            else m_bubble = m_bubble + 32'd1;
            if (stall) begin
                m_wb_regwr = 1'b0;
                m_wb_rw    = 5'd0;
            end else begin
                m_wb_regwr = m_mem_regwr;
                m_wb_rw    = m_mem_rw;
                m_wb_data  = m_mem_mtr ? dm_rdata : m_mem_alu;
                if (flush) begin
                    {m_mem_valid, m_mem_regwr, m_mem_mtr, m_mem_mw} = 4'b0;
                    m_mem_rw = 5'd0; m_mem_alu = 32'd0; m_mem_sdata = 32'd0;
                end else begin
                    m_mem_valid = ex_valid;
                    m_mem_rw    = ex_rw;
                    m_mem_regwr = ex_valid && ex_regwr && (ex_rw != 5'd0);
                    m_mem_mtr   = ex_memtoreg;
                    m_mem_mw    = ex_memwr;
                    m_mem_alu   = ex_alu;
                    m_mem_sdata = ex_sdata;
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle all outputs are meaningful, so compare them all just after the edge.
    always @(posedge clk) begin
        #1;
        check_output("mem_rw", {27'd0, mem_rw}, {27'd0, m_mem_rw});
        check_output("mem_regwr", {31'd0, mem_regwr}, {31'd0, m_mem_regwr});
        check_output("mem_memtoreg", {31'd0, mem_memtoreg}, {31'd0, m_mem_mtr});
        check_output("mem_alu", mem_alu, m_mem_alu);
        check_output("dm_addr", dm_addr, m_mem_alu);
        check_output("dm_wdata", dm_wdata, m_mem_sdata);
        check_output("dm_we", {31'd0, dm_we}, {31'd0, m_mem_mw & m_mem_valid & ~stall});
        check_output("wr_rw", {27'd0, wr_rw}, {27'd0, m_wb_rw});
        check_output("wr_regwr", {31'd0, wr_regwr}, {31'd0, m_wb_regwr});
        check_output("wr_data", wr_data, m_wb_data);
`ifdef PIPE_PERF_CNT_EN
        check_output("retired_cnt", retired_cnt, m_retired);
        check_output("bubble_cnt", bubble_cnt, m_bubble);
`endif
    end

    task automatic apply_stimulus(input logic v, input logic [4:0] rw, input logic rg,
                                  input logic mtr, input logic mw, input logic [31:0] alu,
                                  input logic [31:0] sd, input logic st, input logic fl,
                                  input logic [31:0] rd);
        @(negedge clk);
        ex_valid = v; ex_rw = rw; ex_regwr = rg; ex_memtoreg = mtr; ex_memwr = mw;
        ex_alu = alu; ex_sdata = sd; stall = st; flush = fl; dm_rdata = rd;
    endtask

    task automatic apply_nop(input logic st, input logic [31:0] rd);
        apply_stimulus(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, st, 1'b0, rd);
    endtask

    task automatic next_edge();
        @(posedge clk);
        #2;
    endtask

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] bubble_base;
`endif

    initial begin
        rst = 1'b1;
        ex_valid = 0; ex_rw = 0; ex_regwr = 0; ex_memtoreg = 0; ex_memwr = 0;
        ex_alu = 0; ex_sdata = 0; stall = 0; flush = 0; dm_rdata = 0;
        repeat (2) @(posedge clk);
        #2;
        check_output("reset mem_regwr", {31'd0, mem_regwr}, 32'd0);
        check_output("reset wr_data", wr_data, 32'd0);
        check_output("reset dm_we", {31'd0, dm_we}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // ALU op to $8
        apply_stimulus(1, 5'd8, 1, 0, 0, 32'h1234, 32'd0, 0, 0, 32'd0);
        next_edge();
        check_output("alu mem_rw", {27'd0, mem_rw}, 32'd8);
        check_output("alu mem_regwr", {31'd0, mem_regwr}, 32'd1);
        check_output("alu mem_alu", mem_alu, 32'h1234);
        apply_nop(0, 32'd0);
        next_edge();
        check_output("alu wr_rw", {27'd0, wr_rw}, 32'd8);
        check_output("alu wr_regwr", {31'd0, wr_regwr}, 32'd1);
        check_output("alu wr_data", wr_data, 32'h1234);

        // Write to $0 is suppressed in both stages
        apply_stimulus(1, 5'd0, 1, 0, 0, 32'h5, 32'd0, 0, 0, 32'd0);
        next_edge();
        check_output("r0 mem_regwr", {31'd0, mem_regwr}, 32'd0);
        apply_nop(0, 32'd0);
        next_edge();
        check_output("r0 wr_regwr", {31'd0, wr_regwr}, 32'd0);

        // Load: address in MEM, read data selected into WB
        apply_stimulus(1, 5'd3, 1, 1, 0, 32'h40, 32'd0, 0, 0, 32'd0);
        next_edge();
        check_output("ld mem_memtoreg", {31'd0, mem_memtoreg}, 32'd1);
        check_output("ld dm_addr", dm_addr, 32'h40);
        apply_nop(0, 32'hDEAD);
        next_edge();
        check_output("ld wr_data", wr_data, 32'hDEAD);
        check_output("ld wr_rw", {27'd0, wr_rw}, 32'd3);

        // Store held by a 2-cycle stall: strobe only on the release cycle
        apply_stimulus(1, 5'd0, 0, 0, 1, 32'h80, 32'hCAFE, 0, 0, 32'd0);
        next_edge();
`ifdef PIPE_PERF_CNT_EN
        bubble_base = bubble_cnt;
`endif
        for (int i = 0; i < 2; i++) begin
            apply_nop(1, 32'd0);
            #1;
            check_output("st stall dm_we", {31'd0, dm_we}, 32'd0);
            next_edge();
            check_output("st stall wr_regwr", {31'd0, wr_regwr}, 32'd0);
        end
        apply_nop(0, 32'd0);
        #1;
        check_output("st release dm_we", {31'd0, dm_we}, 32'd1);
        check_output("st dm_wdata", dm_wdata, 32'hCAFE);
        check_output("st dm_addr", dm_addr, 32'h80);
`ifdef PIPE_PERF_CNT_EN
        check_output("st bubble_cnt", bubble_cnt, bubble_base + 32'd2);
`endif
        next_edge();
        check_output("st after dm_we", {31'd0, dm_we}, 32'd0);

        // Flush kills the EX instruction
        apply_stimulus(1, 5'd9, 1, 0, 0, 32'h99, 32'd0, 0, 1, 32'd0);
        next_edge();
        check_output("fl mem_regwr", {31'd0, mem_regwr}, 32'd0);
        check_output("fl mem_rw", {27'd0, mem_rw}, 32'd0);
        apply_nop(0, 32'd0);
        next_edge();
        check_output("fl wr_regwr", {31'd0, wr_regwr}, 32'd0);

        // Flush together with stall leaves EX/MEM unchanged
        apply_stimulus(1, 5'd10, 1, 0, 0, 32'hA, 32'd0, 0, 0, 32'd0);
        next_edge();
        apply_stimulus(1, 5'd11, 1, 0, 0, 32'hB, 32'd0, 1, 1, 32'd0);
        next_edge();
        check_output("flst mem_rw", {27'd0, mem_rw}, 32'd10);
        check_output("flst mem_alu", mem_alu, 32'hA);
        check_output("flst wr_regwr", {31'd0, wr_regwr}, 32'd0);
        apply_nop(0, 32'd0);
        next_edge();
        check_output("flst wr_rw", {27'd0, wr_rw}, 32'd10);
        check_output("flst wr_data", wr_data, 32'hA);

        // Reset mid-stall discards the pending store
        apply_stimulus(1, 5'd12, 1, 0, 1, 32'hC, 32'hD, 0, 0, 32'd0);
        next_edge();
        apply_nop(1, 32'd0);
        #2;
        rst = 1'b1;
        #1;
        check_output("rst mem_rw", {27'd0, mem_rw}, 32'd0);
        check_output("rst mem_alu", mem_alu, 32'd0);
        check_output("rst dm_we", {31'd0, dm_we}, 32'd0);
        check_output("rst wr_rw", {27'd0, wr_rw}, 32'd0);
        check_output("rst wr_data", wr_data, 32'd0);
        apply_stimulus(1, 5'd13, 1, 0, 0, 32'hE, 32'd0, 0, 0, 32'd0);
        rst = 1'b0;
        next_edge();
        check_output("post mem_rw", {27'd0, mem_rw}, 32'd13);
        apply_nop(0, 32'd0);
        next_edge();
        check_output("post wr_rw", {27'd0, wr_rw}, 32'd13);
        check_output("post wr_data", wr_data, 32'hE);

        // Mixed directed tail checked by the model only
        apply_stimulus(1, 5'd20, 1, 0, 0, 32'h11110000, 32'd0, 0, 0, 32'd0);
        apply_stimulus(1, 5'd21, 1, 1, 0, 32'h44, 32'd0, 0, 0, 32'd0);
        apply_stimulus(1, 5'd22, 0, 0, 1, 32'h48, 32'h77, 0, 0, 32'h5A5A);
        apply_stimulus(0, 5'd23, 1, 0, 0, 32'h1, 32'd0, 1, 0, 32'd0);
        apply_stimulus(1, 5'd24, 1, 0, 0, 32'h2, 32'd0, 0, 1, 32'd0);
        apply_nop(0, 32'd0);
        apply_nop(0, 32'd0);
        next_edge();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
